// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit.
//   SZ_BYTE/SZ_HALF/SZ_WORD : access size encodings on the size bus (2'b11 behaves as word)
//   state_e                 : access FSM state (IDLE=0, MERGE=1)
//   is_misaligned()         : alignment rule shared by the top-level decode
package mem_access_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_e;

    // Bytes are never misaligned; size 2'b11 follows the word rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (size == SZ_HALF) begin
            bad = off[0];
        end else if (size[1]) begin
            bad = (off != 2'b00);
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bus bundle between the core, the memory access unit and the word-wide data RAM.
//   core side : mem_read, mem_write, size, unsigned_ld, addr, wdata -> unit
//               load_data, stall, misalign, err_sticky            <- unit
//   RAM side  : ram_rdata -> unit; ram_write, ram_addr, ram_wdata <- unit
// The master modport is the environment (core + RAM); the slave modport is the unit.
interface mem_access_unit_if #(
    parameter int unsigned RAM_AW = 14
);

    logic              mem_read;
    logic              mem_write;
    logic [1:0]        size;
    logic              unsigned_ld;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       ram_rdata;
    logic              ram_write;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       load_data;
    logic              stall;
    logic              misalign;
    logic              err_sticky;

    modport master (
        output mem_read, mem_write, size, unsigned_ld, addr, wdata, ram_rdata,
        input  ram_write, ram_addr, ram_wdata, load_data, stall, misalign, err_sticky
    );

    modport slave (
        input  mem_read, mem_write, size, unsigned_ld, addr, wdata, ram_rdata,
        output ram_write, ram_addr, ram_wdata, load_data, stall, misalign, err_sticky
    );

endinterface

// File: rtl/mem_access_unit_lane_logic.sv
// Pure combinational byte-lane logic (little-endian, lane0 = bits 7:0).
//   size, off     : access size and byte offset within the word
//   unsigned_ld   : 1 zero-extends sub-word loads, 0 sign-extends
//   rdata         : word read from RAM
//   wdata         : store data, sub-word data in the low bits
//   load_val      : selected lane(s), extended to 32 bits
//   merged        : rdata with the target lane(s) replaced by wdata
module mem_access_unit_lane_logic
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        unsigned_ld,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [4:0]  bshamt;
    logic [4:0]  hshamt;
    logic [31:0] bshift;
    logic [31:0] hshift;

    always_comb begin
        bshamt   = {off, 3'b000};
        hshamt   = {off[1], 4'b0000};
        bshift   = rdata >> bshamt;
        hshift   = rdata >> hshamt;
        load_val = rdata;
        merged   = wdata;
        case (size)
            SZ_BYTE: begin
                load_val = unsigned_ld ? {24'b0, bshift[7:0]} : {{24{bshift[7]}}, bshift[7:0]};
                merged   = (rdata & ~(32'h0000_00ff << bshamt))
                         | ((wdata & 32'h0000_00ff) << bshamt);
            end
            SZ_HALF: begin
                load_val = unsigned_ld ? {16'b0, hshift[15:0]} : {{16{hshift[15]}}, hshift[15:0]};
                merged   = (rdata & ~(32'h0000_ffff << hshamt))
                         | ((wdata & 32'h0000_ffff) << hshamt);
            end
            SZ_WORD, 2'b11: begin
                load_val = rdata;
                merged   = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit between the execute stage and a word-only RAM clocked on ~clock.
// Word accesses pass straight through; byte/half loads are extracted and extended in the
// same cycle; byte/half stores use a two-cycle read-modify-write (IDLE reads, MERGE writes)
// and stall the core during the first cycle. Misaligned requests raise misalign, write
// nothing and set err_sticky.
//   clock, reset : core clock, synchronous active-high reset
//   bus          : core request/response and RAM port signals (slave modport)
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned RAM_AW = 14
) (
    input logic                clock,
    input logic                reset,
    mem_access_unit_if.slave   bus
);

    state_e            state;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic [31:0]       wdata_q;
    logic [RAM_AW-1:0] waddr_q;
    logic              err_q;

    logic              req;
    logic              mis;
    logic              sub_store;
    logic [RAM_AW-1:0] word_addr;
    logic [1:0]        ll_size;
    logic [1:0]        ll_off;
    logic [31:0]       ll_wdata;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    logic              ram_write_c;
    logic [RAM_AW-1:0] ram_addr_c;
    logic [31:0]       ram_wdata_c;
    logic [31:0]       load_data_c;
    logic              stall_c;

    // Upper address bits select IO upstream and are not needed here.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[31:RAM_AW+2];

    assign word_addr = bus.addr[RAM_AW+1:2];
    assign req       = bus.mem_read | bus.mem_write;
    // Live inputs only matter in IDLE; MERGE works from the latched request.
    assign mis       = (state == IDLE) && req && is_misaligned(bus.size, bus.addr[1:0]);
    assign sub_store = (state == IDLE) && bus.mem_write && !mis && !bus.size[1];

    // One lane block serves both the IDLE load path and the MERGE write path.
    assign ll_size  = (state == MERGE) ? size_q  : bus.size;
    assign ll_off   = (state == MERGE) ? off_q   : bus.addr[1:0];
    assign ll_wdata = (state == MERGE) ? wdata_q : bus.wdata;

    mem_access_unit_lane_logic u_lane (
        .size        (ll_size),
        .off         (ll_off),
        .unsigned_ld (bus.unsigned_ld),
        .rdata       (bus.ram_rdata),
        .wdata       (ll_wdata),
        .load_val    (load_val),
        .merged      (merged)
    );

    always_comb begin
        ram_write_c = 1'b0;
        ram_addr_c  = word_addr;
        ram_wdata_c = bus.wdata;
        load_data_c = 32'h0;
        stall_c     = 1'b0;
        case (state)
            IDLE: begin
                if (!mis) begin
                    if (bus.mem_read) begin
                        load_data_c = load_val;
                    end
                    // Store wins over a simultaneous load; load_data is still driven.
                    if (bus.mem_write) begin
                        if (bus.size[1]) begin
                            ram_write_c = 1'b1;
                        end else begin
                            stall_c = 1'b1;
                        end
                    end
                end
            end
            MERGE: begin
                ram_addr_c  = waddr_q;
                ram_wdata_c = merged;
                ram_write_c = 1'b1;
            end
        endcase
        // Reset must squash an in-flight merge before the RAM's negedge write.
        if (reset) begin
            ram_write_c = 1'b0;
            stall_c     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            err_q   <= 1'b0;
            off_q   <= 2'b00;
            size_q  <= SZ_BYTE;
            wdata_q <= 32'h0;
            waddr_q <= '0;
        end else begin
            if (mis) begin
                err_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (sub_store) begin
                        off_q   <= bus.addr[1:0];
                        size_q  <= bus.size;
                        wdata_q <= bus.wdata;
                        waddr_q <= word_addr;
                        state   <= MERGE;
                    end
                end
                MERGE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ram_write  = ram_write_c;
    assign bus.ram_addr   = ram_addr_c;
    assign bus.ram_wdata  = ram_wdata_c;
    assign bus.load_data  = load_data_c;
    assign bus.stall      = stall_c;
    assign bus.misalign   = mis;
    assign bus.err_sticky = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a negedge word RAM, a byte-addressed reference memory,
// directed scenarios followed by randomized accesses.
module tb_mem_access_unit;

    localparam int unsigned RAM_AW = 14;

    logic clock;
    logic reset;

    mem_access_unit_if #(.RAM_AW(RAM_AW)) bus ();

    mem_access_unit #(.RAM_AW(RAM_AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word RAM clocked on ~clock; read returns the old word on a simultaneous write.
    logic [31:0] ram [0:(1<<RAM_AW)-1];
    always @(negedge clock) begin
        if (bus.ram_write) ram[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= ram[bus.ram_addr];
    end

    // Reference: byte-addressed memory covering the low 256 bytes.
    logic [7:0] mb [0:255];
    logic       err_exp;

    int passed;
    int failed;
    int total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int b;
        b = int'(a[7:0]) & ~3;
        return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                               input logic [31:0] a);
        int b;
        logic [7:0]  v8;
        logic [15:0] v16;
        b = int'(a[7:0]);
        if (sz == 2'd0) begin
            v8 = mb[b];
            return uns ? {24'h0, v8} : {{24{v8[7]}}, v8};
        end else if (sz == 2'd1) begin
            v16 = {mb[b+1], mb[b]};
            return uns ? {16'h0, v16} : {{16{v16[15]}}, v16};
        end
        return model_word(a);
    endfunction

    function automatic void model_store(input logic [1:0] sz, input logic [31:0] a,
                                        input logic [31:0] d);
        int b;
        int n;
        b = int'(a[7:0]);
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) mb[b+i] = d[8*i +: 8];
    endfunction

    task automatic set_req(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] wd);
        bus.mem_read    = rd;
        bus.mem_write   = wr;
        bus.size        = sz;
        bus.unsigned_ld = uns;
        bus.addr        = a;
        bus.wdata       = wd;
    endtask

    // Called at posedge+1; issues one request, holds it through any stall, returns at
    // posedge+1 after completion. Observed IDLE-cycle load_data is returned in ld_obs.
    task automatic access(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] ld_obs);
        logic        m;
        logic        exp_stall;
        logic        exp_wr;
        logic [31:0] exp_ld;
        m         = (rd | wr) && model_mis(sz, a);
        exp_ld    = (rd && !m) ? model_load(sz, uns, a) : 32'h0;
        exp_stall = wr && !m && (sz < 2'd2);
        exp_wr    = wr && !m && (sz >= 2'd2);
        set_req(rd, wr, sz, uns, a, wd);
        #8;
        chk("misalign", 32'(bus.misalign), 32'(m));
        chk("load_data", bus.load_data, exp_ld);
        chk("stall", 32'(bus.stall), 32'(exp_stall));
        chk("ram_write", 32'(bus.ram_write), 32'(exp_wr));
        if (exp_wr) chk("ram_wdata_word", bus.ram_wdata, wd);
        if (!m && (rd | wr)) chk("ram_addr", 32'(bus.ram_addr), 32'(a[RAM_AW+1:2]));
        ld_obs = bus.load_data;
        @(posedge clock); #1;
        if (wr && !m) model_store(sz, a, wd);
        if (m) err_exp = 1'b1;
        if (exp_stall) begin
            #8;
            chk("merge_stall", 32'(bus.stall), 32'h0);
            chk("merge_write", 32'(bus.ram_write), 32'h1);
            chk("merge_addr", 32'(bus.ram_addr), 32'(a[RAM_AW+1:2]));
            chk("merge_wdata", bus.ram_wdata, model_word(a));
            @(posedge clock); #1;
        end
        chk("err_sticky", 32'(bus.err_sticky), 32'(err_exp));
    endtask

    logic [31:0] ld;
    logic [31:0] ra;
    logic [1:0]  rs;
    logic        rr;
    logic        rw;

    initial begin
        passed  = 0;
        failed  = 0;
        total   = 0;
        err_exp = 1'b0;
        for (int i = 0; i < (1 << RAM_AW); i++) ram[i] = 32'h0;
        for (int i = 0; i < 256; i++) mb[i] = 8'h0;
        ram[4] = 32'h8877_6655;
        model_store(2'd2, 32'h10, 32'h8877_6655);
        set_req(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ram_write", 32'(bus.ram_write), 32'h0);
        chk("rst_stall", 32'(bus.stall), 32'h0);
        chk("rst_err", 32'(bus.err_sticky), 32'h0);
        chk("rst_misalign", 32'(bus.misalign), 32'h0);
        chk("rst_load", bus.load_data, 32'h0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Sub-word loads with sign/zero extension.
        access(1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, ld);
        chk("lb_0x13", ld, 32'hffff_ff88);
        access(1'b1, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, ld);
        chk("lhu_0x12", ld, 32'h0000_8877);
        access(1'b1, 1'b0, 2'd1, 1'b0, 32'h10, 32'h0, ld);
        chk("lh_0x10", ld, 32'h0000_6655);

        // Byte store via read-modify-write.
        access(1'b0, 1'b1, 2'd0, 1'b0, 32'h11, 32'hffff_ffab, ld);
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, ld);
        chk("lw_after_sb", ld, 32'h8877_ab55);

        // Word store, misaligned half load and store.
        access(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h1234_5678, ld);
        access(1'b1, 1'b0, 2'd1, 1'b0, 32'h21, 32'h0, ld);
        chk("lh_mis_load", ld, 32'h0);
        access(1'b0, 1'b1, 2'd1, 1'b0, 32'h23, 32'h0000_dead, ld);
        chk("word20_kept", ram[8], 32'h1234_5678);
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, ld);
        chk("lw_0x20", ld, 32'h1234_5678);

        // Reset during MERGE squashes the write.
        set_req(1'b0, 1'b1, 2'd1, 1'b0, 32'h10, 32'h0000_beef);
        #8;
        chk("sh_stall", 32'(bus.stall), 32'h1);
        @(posedge clock); #1;
        reset = 1'b1;
        #8;
        chk("rst_merge_write", 32'(bus.ram_write), 32'h0);
        chk("rst_merge_stall", 32'(bus.stall), 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        err_exp = 1'b0;
        set_req(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        chk("rst_err_clear", 32'(bus.err_sticky), 32'h0);
        chk("rst_word_kept", ram[4], 32'h8877_ab55);

        // Back-to-back byte stores; the first also shows the FSM is back in IDLE.
        access(1'b0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00ab, ld);
        access(1'b0, 1'b1, 2'd0, 1'b0, 32'h12, 32'h0000_00cc, ld);
        chk("b2b_word", ram[4], 32'h88cc_ab55);

        // Randomized mix, including idle cycles, misaligned and simultaneous read/write.
        for (int n = 0; n < 300; n++) begin
            rr = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            rs = 2'($urandom_range(0, 3));
            ra = 32'($urandom_range(0, 63)) | ({$urandom} & 32'hfff0_0000);
            access(rr, rw, rs, 1'($urandom_range(0, 1)), ra, $urandom, ld);
        end
        set_req(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        @(posedge clock); #1;
        for (int w = 0; w < 16; w++) begin
            chk("final_ram", ram[w], model_word(32'(w * 4)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
